// File: rtl/vga_sync_receiver.sv
// Recovers VGA timing from an incoming HSYNC/VSYNC pair: measures line/frame geometry,
// locks once consecutive frames agree, then reconstructs active-area pixel coordinates.
module vga_sync_receiver #(
  parameter int HSYNC_BITS       = 11,
  parameter int VSYNC_BITS       = 11,
  parameter int HD               = 1280,
  parameter int HR               = 112,
  parameter int HB               = 248,
  parameter int VD               = 1024,
  parameter int VR               = 3,
  parameter int VB               = 38,
  parameter int LOCK_FRAMES      = 2,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic                  locked,
  output logic                  pixel_valid,
  output logic [HSYNC_BITS-1:0] x,
  output logic [VSYNC_BITS-1:0] y,
  output logic                  frame_start,
  output logic [HSYNC_BITS-1:0] line_len,
  output logic [HSYNC_BITS-1:0] hs_width,
  output logic [VSYNC_BITS-1:0] frame_lines,
  output logic [VSYNC_BITS-1:0] vs_width,
  output logic                  timing_err
);

  localparam logic [HSYNC_BITS-1:0] H_MAX = {HSYNC_BITS{1'b1}};
  localparam logic [HSYNC_BITS-1:0] H_ONE = HSYNC_BITS'(1);
  localparam logic [HSYNC_BITS-1:0] H_OFF = HSYNC_BITS'(HR + HB);
  localparam logic [HSYNC_BITS:0]   H_LO  = (HSYNC_BITS+1)'(HR + HB);
  localparam logic [HSYNC_BITS:0]   H_HI  = (HSYNC_BITS+1)'(HR + HB + HD);
  localparam logic [VSYNC_BITS-1:0] V_MAX = {VSYNC_BITS{1'b1}};
  localparam logic [VSYNC_BITS-1:0] V_ONE = VSYNC_BITS'(1);
  localparam logic [VSYNC_BITS-1:0] V_OFF = VSYNC_BITS'(VR + VB);
  localparam logic [VSYNC_BITS:0]   V_LO  = (VSYNC_BITS+1)'(VR + VB);
  localparam logic [VSYNC_BITS:0]   V_HI  = (VSYNC_BITS+1)'(VR + VB + VD);
  localparam logic [7:0]            LOCK_N = 8'(LOCK_FRAMES);
  localparam int                    SNAP_W = 2*HSYNC_BITS + 2*VSYNC_BITS;

  logic                  hs_norm, vs_norm;
  logic [2:0]            hs_sync;
  logic [1:0]            vs_sync;
  logic [HSYNC_BITS-1:0] h_cnt, h_inc, new_line_len;
  logic [VSYNC_BITS-1:0] v_cnt, v_inc;
  logic                  vs_prev, have_line, frame_bad;
  logic [1:0]            hist_cnt;
  logic [7:0]            match_cnt;
  logic [SNAP_W-1:0]     snap, snap_now;
  logic                  hs_rise, hs_fall, vs_now, h_sat, v_sat;
  logic                  line_err, h_sat_err, v_sat_err, fs, vs_end, qualify;
  logic                  h_in, v_in;

  // Flops hold the normalized level so reset (0) always means "outside the pulse".
  assign hs_norm = (SYNC_ACTIVE_HIGH != 0) ? hs_i : ~hs_i;
  assign vs_norm = (SYNC_ACTIVE_HIGH != 0) ? vs_i : ~vs_i;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hs_sync <= '0;
      vs_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[1:0], hs_norm};
      vs_sync <= {vs_sync[0], vs_norm};
    end
  end

  assign hs_rise   = hs_sync[1] & ~hs_sync[2];
  assign hs_fall   = ~hs_sync[1] & hs_sync[2];
  assign vs_now    = vs_sync[1];
  assign h_sat     = (h_cnt == H_MAX);
  assign v_sat     = (v_cnt == V_MAX);
  assign h_inc     = h_cnt + H_ONE;
  assign v_inc     = v_cnt + V_ONE;
  assign fs        = hs_rise && vs_now && !vs_prev;
  assign vs_end    = hs_rise && !vs_now && vs_prev;
  assign line_err  = hs_rise && !h_sat && have_line && (h_inc != line_len);
  assign h_sat_err = !hs_rise && (h_cnt == H_MAX - H_ONE);
  assign v_sat_err = hs_rise && !fs && (v_cnt == V_MAX - V_ONE);

  // Snapshot compares the values this frame start is about to register.
  assign new_line_len = h_sat ? line_len : h_inc;
  assign snap_now     = {new_line_len, hs_width, v_inc, vs_width};
  assign qualify      = fs && (hist_cnt == 2'd2) && !frame_bad && !line_err && (snap_now == snap);

  assign h_in = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
  assign v_in = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vs_prev     <= 1'b0;
      have_line   <= 1'b0;
      frame_bad   <= 1'b0;
      hist_cnt    <= '0;
      match_cnt   <= '0;
      snap        <= '0;
      locked      <= 1'b0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
      hs_width    <= '0;
      frame_lines <= '0;
      vs_width    <= '0;
      timing_err  <= 1'b0;
    end else begin
      frame_start <= fs;
      timing_err  <= line_err | h_sat_err | v_sat_err;

      if (hs_rise)     h_cnt <= '0;
      else if (!h_sat) h_cnt <= h_inc;
      if (hs_fall) hs_width <= h_inc;
      if (hs_rise && !h_sat) begin
        line_len  <= h_inc;
        have_line <= 1'b1;
      end

      if (hs_rise) begin
        vs_prev <= vs_now;
        if (fs) begin
          frame_lines <= v_inc;
          v_cnt       <= '0;
        end else begin
          if (vs_end) vs_width <= v_inc;
          if (!v_sat) v_cnt <= v_inc;
        end
      end

      if (fs) begin
        frame_bad <= 1'b0;
        snap      <= snap_now;
        if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
        if (!qualify)                match_cnt <= '0;
        else if (match_cnt != LOCK_N) match_cnt <= match_cnt + 8'd1;
      end else if (line_err) begin
        frame_bad <= 1'b1;
      end

      // A fault registered last cycle drops lock and overrides any frame-start count.
      if (timing_err) begin
        locked    <= 1'b0;
        match_cnt <= '0;
      end else if (match_cnt == LOCK_N) begin
        locked <= 1'b1;
      end

      x           <= h_cnt - H_OFF;
      y           <= v_cnt - V_OFF;
      pixel_valid <= locked && h_in && v_in;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Drives a scaled-down sync stream into an active-high and an active-low receiver and
// checks measurements, lock behaviour, fault pulses and the pixel window against a scoreboard.
module tb_vga_sync_receiver;

  localparam int P_HBITS = 8;
  localparam int P_VBITS = 8;
  localparam int P_HD = 24, P_HR = 4, P_HB = 6;
  localparam int P_VD = 12, P_VR = 2, P_VB = 3;
  localparam int LINE = 40, HSW = 4, NLINES = 20, VSW = 2;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic hs_i = 1'b0;
  logic vs_i = 1'b0;
  logic hs_inv, vs_inv;
  assign hs_inv = ~hs_i;
  assign vs_inv = ~vs_i;

  always #5 clk = ~clk;

  logic               lk_o[2], pv_o[2], fs_o[2], te_o[2];
  logic [P_HBITS-1:0] x_o[2], ll_o[2], hw_o[2];
  logic [P_VBITS-1:0] y_o[2], fl_o[2], vw_o[2];

  vga_sync_receiver #(
    .HSYNC_BITS(P_HBITS), .VSYNC_BITS(P_VBITS), .HD(P_HD), .HR(P_HR), .HB(P_HB),
    .VD(P_VD), .VR(P_VR), .VB(P_VB), .LOCK_FRAMES(2), .SYNC_ACTIVE_HIGH(1)
  ) dut_pos (
    .clk(clk), .arstn(arstn), .hs_i(hs_i), .vs_i(vs_i),
    .locked(lk_o[0]), .pixel_valid(pv_o[0]), .x(x_o[0]), .y(y_o[0]),
    .frame_start(fs_o[0]), .line_len(ll_o[0]), .hs_width(hw_o[0]),
    .frame_lines(fl_o[0]), .vs_width(vw_o[0]), .timing_err(te_o[0])
  );

  vga_sync_receiver #(
    .HSYNC_BITS(P_HBITS), .VSYNC_BITS(P_VBITS), .HD(P_HD), .HR(P_HR), .HB(P_HB),
    .VD(P_VD), .VR(P_VR), .VB(P_VB), .LOCK_FRAMES(2), .SYNC_ACTIVE_HIGH(0)
  ) dut_neg (
    .clk(clk), .arstn(arstn), .hs_i(hs_inv), .vs_i(vs_inv),
    .locked(lk_o[1]), .pixel_valid(pv_o[1]), .x(x_o[1]), .y(y_o[1]),
    .frame_start(fs_o[1]), .line_len(ll_o[1]), .hs_width(hw_o[1]),
    .frame_lines(fl_o[1]), .vs_width(vw_o[1]), .timing_err(te_o[1])
  );

  typedef struct {
    int bad_line;
    bit chk;
    bit lck;
  } frame_rec_t;

  typedef struct {
    bit chk;
    int ll;
    int hsw;
    int fl;
    int vsw;
    bit lck;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   tests = 0;
  int   fails = 0;
  int   err_cnt[2];
  int   te_run[2];
  int   pend[2];
  exp_t cur[2];
  int   fv_cnt[2], pv_run[2], fcyc[2];
  int   fx[2], fy[2], lx[2], ly[2];
  bit   clean[2];

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit chk, input bit lck);
    exp_t e;
    e.chk = chk; e.ll = LINE; e.hsw = HSW; e.fl = NLINES; e.vsw = VSW; e.lck = lck;
    sbq0.push_back(e);
    sbq1.push_back(e);
  endtask

  task automatic drive_line(input int len, input bit vs);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hs_i = (i < HSW);
      vs_i = vs;
    end
  endtask

  // The lengthened line is caught at the next line's hs_rise (3 edges after the drive).
  task automatic err_seq();
    @(negedge clk);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("err_pulse_high", d, te_o[d], 1);
      check("lock_held_1cyc", d, lk_o[d], 1);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("err_pulse_low", d, te_o[d], 0);
      check("lock_lost", d, lk_o[d], 0);
    end
  endtask

  task automatic drive_frame(input frame_rec_t r);
    push_exp(r.chk, r.lck);
    for (int l = 0; l < NLINES; l++) begin
      if (r.bad_line >= 0 && l == r.bad_line + 1) begin
        fork
          err_seq();
        join_none
      end
      drive_line((l == r.bad_line) ? LINE + 1 : LINE, l < VSW);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    int   qs;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (te_o[d]) begin
          err_cnt[d]++;
          te_run[d]++;
        end else if (te_run[d] > 0) begin
          check("te_pulse_len", d, te_run[d], 1);
          te_run[d] = 0;
        end

        if (pv_o[d]) begin
          if (fv_cnt[d] == 0) begin
            fx[d] = x_o[d];
            fy[d] = y_o[d];
          end
          lx[d] = x_o[d];
          ly[d] = y_o[d];
          fv_cnt[d]++;
          pv_run[d]++;
        end else if (pv_run[d] > 0) begin
          check("line_run", d, pv_run[d], P_HD);
          pv_run[d] = 0;
        end

        fcyc[d]++;
        if (!lk_o[d] && fcyc[d] > 4) clean[d] = 1'b0;

        if (pend[d] > 0) begin
          pend[d]--;
          if (pend[d] == 0) begin
            if (cur[d].chk) begin
              check("line_len", d, ll_o[d], cur[d].ll);
              check("hs_width", d, hw_o[d], cur[d].hsw);
              check("frame_lines", d, fl_o[d], cur[d].fl);
              check("vs_width", d, vw_o[d], cur[d].vsw);
            end
            check("locked_at_fs", d, lk_o[d], cur[d].lck);
          end
        end

        if (fs_o[d]) begin
          if (clean[d] && fv_cnt[d] > 0) begin
            check("frame_px", d, fv_cnt[d], P_HD * P_VD);
            check("first_x", d, fx[d], 0);
            check("first_y", d, fy[d], 0);
            check("last_x", d, lx[d], P_HD - 1);
            check("last_y", d, ly[d], P_VD - 1);
          end
          fv_cnt[d] = 0;
          fcyc[d] = 0;
          clean[d] = 1'b1;
          qs = (d == 0) ? sbq0.size() : sbq1.size();
          check("sb_has_entry", d, (qs > 0), 1);
          if (qs > 0) begin
            if (d == 0) e = sbq0.pop_front();
            else        e = sbq1.pop_front();
            cur[d] = e;
            pend[d] = 2;
          end
        end
      end
    end
  endtask

  initial begin
    frame_rec_t tbl[9];
    int e0[2];
    tbl[0] = '{-1, 0, 0};
    tbl[1] = '{-1, 1, 0};
    tbl[2] = '{-1, 1, 0};
    tbl[3] = '{-1, 1, 1};
    tbl[4] = '{ 7, 1, 1};
    tbl[5] = '{-1, 1, 0};
    tbl[6] = '{-1, 1, 0};
    tbl[7] = '{-1, 1, 1};
    tbl[8] = '{-1, 1, 1};
    for (int d = 0; d < 2; d++) begin
      err_cnt[d] = 0; te_run[d] = 0; pend[d] = 0; fv_cnt[d] = 0;
      pv_run[d] = 0; fcyc[d] = 0; clean[d] = 1'b0;
      fx[d] = 0; fy[d] = 0; lx[d] = 0; ly[d] = 0;
    end

    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_locked", d, lk_o[d], 0);
      check("rst_meas", d, {ll_o[d], hw_o[d], fl_o[d], vw_o[d]}, 0);
      check("rst_misc", d, {pv_o[d], fs_o[d], te_o[d], x_o[d], y_o[d]}, 0);
    end
    arstn = 1'b1;
    repeat (3) @(negedge clk);

    // Acquire lock, then one lengthened line and relock.
    for (int i = 0; i < 9; i++) drive_frame(tbl[i]);

    // hs held inactive long enough to saturate h_cnt.
    push_exp(1, 1);
    for (int l = 0; l < 5; l++) drive_line(LINE, l < VSW);
    e0[0] = err_cnt[0]; e0[1] = err_cnt[1];
    repeat (400) begin
      @(negedge clk);
      hs_i = 1'b0;
      vs_i = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      check("hsat_err_cnt", d, err_cnt[d] - e0[d], 1);
      check("hsat_locked", d, lk_o[d], 0);
      check("hsat_line_len", d, ll_o[d], LINE);
    end
    drive_frame('{-1, 0, 0});
    drive_frame('{-1, 1, 0});
    drive_frame('{-1, 1, 0});
    drive_frame('{-1, 1, 1});

    // Asynchronous reset mid-frame while locked.
    push_exp(1, 1);
    for (int l = 0; l < 10; l++) drive_line(LINE, l < VSW);
    check("pre_rst_q", 0, sbq0.size(), 0);
    check("pre_rst_q", 1, sbq1.size(), 0);
    for (int d = 0; d < 2; d++) check("pre_rst_locked", d, lk_o[d], 1);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("arst_locked", d, lk_o[d], 0);
      check("arst_meas", d, {ll_o[d], hw_o[d], fl_o[d], vw_o[d]}, 0);
      check("arst_misc", d, {pv_o[d], fs_o[d], te_o[d], x_o[d], y_o[d]}, 0);
    end
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_frame(tbl[i]);
    drive_frame(tbl[8]);

    // No vsync for long enough to saturate v_cnt.
    e0[0] = err_cnt[0]; e0[1] = err_cnt[1];
    repeat (260) drive_line(LINE, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check("vsat_err_cnt", d, err_cnt[d] - e0[d], 1);
      check("vsat_locked", d, lk_o[d], 0);
    end

    repeat (10) @(negedge clk);
    check("end_q", 0, sbq0.size(), 0);
    check("end_q", 1, sbq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
